tx_frame_scheduler: RTL and testbench

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

---
 rtl/sys_ctrl_pkg.sv | 17 +
 rtl/tx_hold_timer.sv | 38 +++
 rtl/tx_frame_scheduler.sv | 127 ++++++++++++
 tb/tb_tx_frame_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared constants and state encoding for the TX frame scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sys_ctrl_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int HOLD_CYCLES_DEF = 15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD_LO = 3'd1,
        GAP_LO  = 3'd2,
        HOLD_HI = 3'd3,
        GAP_HI  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/tx_hold_timer.sv
// Hold-phase down counter: flags the last cycle of a HOLD_CYCLES-long hold.
// Latency: o_done is combinational on the counter; load takes effect next cycle.
// Backpressure: none; the caller decides when to load and when to count.
//
// Ports: i_clk, i_rst (sync, active-high), i_load (restart the hold),
//        i_count (hold in progress), o_done (this is the final hold cycle).
module tx_hold_timer
    import sys_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_done
);

    localparam int            CW       = $clog2(HOLD_CYCLES + 1);
    // Loading HOLD_CYCLES-1 makes the count reach zero on the last hold cycle.
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_count && (r_cnt != '0)) begin
            // Saturates at zero: the counter never wraps.
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = i_count && (r_cnt == '0);

endmodule

// File: rtl/tx_frame_scheduler.sv
// Arbitrates RF and ALU requests and serialises each into held TX bytes.
// Latency: TX_VLD rises the cycle after acceptance; RF frame H+2, ALU frame 2H+3 cycles.
// Backpressure: RF_RDY/ALU_RDY only in IDLE; requests stall while BUSY.
//
// Ports: REF_CLK, RST_REF (sync, active-high); RF_DATA/RF_VLD/RF_RDY and
//        ALU_DATA/ALU_VLD/ALU_RDY request channels; TX_OUT/TX_VLD byte
//        output to the TX-domain flag stage; BUSY high outside IDLE.
module tx_frame_scheduler
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                    REF_CLK,
    input  logic                    RST_REF,
    input  logic [DATA_WIDTH-1:0]   RF_DATA,
    input  logic                    RF_VLD,
    output logic                    RF_RDY,
    input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
    input  logic                    ALU_VLD,
    output logic                    ALU_RDY,
    output logic [DATA_WIDTH-1:0]   TX_OUT,
    output logic                    TX_VLD,
    output logic                    BUSY
);

    tx_state_t               r_state;
    tx_state_t               w_next;
    logic [2*DATA_WIDTH-1:0] r_dat;
    logic                    r_src_alu;   // frame in flight came from the ALU
    logic                    r_prio_alu;  // ALU wins the next tie
    logic                    w_grant_rf;
    logic                    w_grant_alu;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_count;
    logic                    w_done;

    // Round-robin grant; only in IDLE and never while reset is applied.
    always_comb begin
        w_grant_rf  = 1'b0;
        w_grant_alu = 1'b0;
        if ((r_state == IDLE) && !RST_REF) begin
            if (RF_VLD && ALU_VLD) begin
                w_grant_alu = r_prio_alu;
                w_grant_rf  = !r_prio_alu;
            end else begin
                w_grant_rf  = RF_VLD;
                w_grant_alu = ALU_VLD;
            end
        end
    end

    assign RF_RDY   = w_grant_rf;
    assign ALU_RDY  = w_grant_alu;
    // A grant is only ever given to a requester whose VLD is high.
    assign w_accept = w_grant_rf || w_grant_alu;

    // Capture the request; TX_OUT is built only from this register.
    always_ff @(posedge REF_CLK) begin
        if (RST_REF) begin
            r_dat      <= '0;
            r_src_alu  <= 1'b0;
            r_prio_alu <= 1'b0;
        end else if (w_accept) begin
            r_src_alu  <= w_grant_alu;
            r_prio_alu <= w_grant_rf;
            r_dat      <= w_grant_alu ? ALU_DATA : {{DATA_WIDTH{1'b0}}, RF_DATA};
        end
    end

    // State register
    always_ff @(posedge REF_CLK) begin
        if (RST_REF) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = HOLD_LO;
            HOLD_LO: if (w_done)   w_next = GAP_LO;
            GAP_LO:  w_next = r_src_alu ? HOLD_HI : IDLE;
            HOLD_HI: if (w_done)   w_next = GAP_HI;
            GAP_HI:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        TX_VLD  = 1'b0;
        TX_OUT  = '0;
        BUSY    = (r_state != IDLE);
        w_count = 1'b0;
        // Timer restarts on entry to either hold state.
        w_load  = ((r_state == IDLE) && w_accept) || ((r_state == GAP_LO) && r_src_alu);
        case (r_state)
            HOLD_LO: begin
                TX_VLD  = 1'b1;
                TX_OUT  = r_dat[DATA_WIDTH-1:0];
                w_count = 1'b1;
            end
            HOLD_HI: begin
                TX_VLD  = 1'b1;
                TX_OUT  = r_dat[2*DATA_WIDTH-1:DATA_WIDTH];
                w_count = 1'b1;
            end
            default: ;
        endcase
    end

    tx_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk   (REF_CLK),
        .i_rst   (RST_REF),
        .i_load  (w_load),
        .i_count (w_count),
        .o_done  (w_done)
    );

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: one instance with the default hold and one
// with a single-cycle hold. Expected bytes go into a scoreboard queue when a
// request is issued; a negedge monitor pops and checks each TX byte run.
module tb_tx_frame_scheduler;

    localparam int H_A = 15;
    localparam int H_B = 1;

    typedef struct {
        int dut;
        int dat;
        int len;
    } exp_t;

    typedef struct {
        int src;
        int cyc;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  rf_data;
    logic        rf_vld;
    logic        rf_rdy;
    logic [15:0] alu_data;
    logic        alu_vld;
    logic        alu_rdy;
    logic [7:0]  tx_out;
    logic        tx_vld;
    logic        busy;

    logic [7:0]  b_rf_data;
    logic        b_rf_vld;
    logic        b_rf_rdy;
    logic [15:0] b_alu_data;
    logic        b_alu_vld;
    logic        b_alu_rdy;
    logic [7:0]  b_tx_out;
    logic        b_tx_vld;
    logic        b_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        exp_q[$];
    acc_t        acc_a[$];
    acc_t        acc_b[$];
    logic [7:0]  rf_vals[4];
    logic [15:0] alu_vals[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_frame_scheduler #(.DATA_WIDTH(8), .HOLD_CYCLES(H_A)) dut_a (
        .REF_CLK  (clk),
        .RST_REF  (rst),
        .RF_DATA  (rf_data),
        .RF_VLD   (rf_vld),
        .RF_RDY   (rf_rdy),
        .ALU_DATA (alu_data),
        .ALU_VLD  (alu_vld),
        .ALU_RDY  (alu_rdy),
        .TX_OUT   (tx_out),
        .TX_VLD   (tx_vld),
        .BUSY     (busy)
    );

    tx_frame_scheduler #(.DATA_WIDTH(8), .HOLD_CYCLES(H_B)) dut_b (
        .REF_CLK  (clk),
        .RST_REF  (rst),
        .RF_DATA  (b_rf_data),
        .RF_VLD   (b_rf_vld),
        .RF_RDY   (b_rf_rdy),
        .ALU_DATA (b_alu_data),
        .ALU_VLD  (b_alu_vld),
        .ALU_RDY  (b_alu_rdy),
        .TX_OUT   (b_tx_out),
        .TX_VLD   (b_tx_vld),
        .BUSY     (b_busy)
    );

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [1:0] m_vld;
    logic [7:0] m_out [2];
    assign m_vld    = {b_tx_vld, tx_vld};
    assign m_out[0] = tx_out;
    assign m_out[1] = b_tx_out;

    bit         in_run   [2];
    bit         unstable [2];
    int         run_len  [2];
    logic [7:0] run_val  [2];
    exp_t       cur      [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_vld[i]) begin
                if (!in_run[i]) begin
                    in_run[i]   = 1'b1;
                    run_len[i]  = 1;
                    run_val[i]  = m_out[i];
                    unstable[i] = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        cur[i] = '{dut: i, dat: int'(m_out[i]), len: -1};
                        $display("FAIL unexpected_byte dut%0d: got 0x%0h, expected no byte", i, m_out[i]);
                    end else begin
                        cur[i] = exp_q.pop_front();
                        check($sformatf("byte_source_dut%0d", i), i, cur[i].dut);
                        check($sformatf("byte_value_dut%0d", i), int'(m_out[i]), cur[i].dat);
                    end
                end else begin
                    run_len[i]++;
                    if (m_out[i] != run_val[i]) unstable[i] = 1'b1;
                end
            end else begin
                if (in_run[i]) begin
                    if (cur[i].len >= 0)
                        check($sformatf("hold_len_dut%0d", i), run_len[i], cur[i].len);
                    check($sformatf("hold_stable_dut%0d", i), int'(unstable[i]), 0);
                    in_run[i] = 1'b0;
                end
                check($sformatf("gap_zero_dut%0d", i), int'(m_out[i]), 0);
            end
        end
    end

    // ---------------- handshake monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rdy_low_in_reset", int'({rf_rdy, alu_rdy, b_rf_rdy, b_alu_rdy}), 0);
        end else begin
            if (rf_vld && rf_rdy)     acc_a.push_back('{src: 0, cyc: cyc});
            if (alu_vld && alu_rdy)   acc_a.push_back('{src: 1, cyc: cyc});
            if (b_rf_vld && b_rf_rdy) acc_b.push_back('{src: 0, cyc: cyc});
            if (b_alu_vld && b_alu_rdy) acc_b.push_back('{src: 1, cyc: cyc});
        end
        check("rdy_exclusive_a", int'(rf_rdy && alu_rdy), 0);
        check("rdy_without_vld_a", int'((rf_rdy && !rf_vld) || (alu_rdy && !alu_vld)), 0);
        check("rdy_while_busy_a", int'((rf_rdy || alu_rdy) && busy), 0);
        check("rdy_exclusive_b", int'(b_rf_rdy && b_alu_rdy), 0);
        check("rdy_without_vld_b", int'((b_rf_rdy && !b_rf_vld) || (b_alu_rdy && !b_alu_vld)), 0);
        check("rdy_while_busy_b", int'((b_rf_rdy || b_alu_rdy) && b_busy), 0);
    end

    // ---------------- stimulus helpers ----------------
    // Holds RF and/or ALU requests on dut_a, stepping through rf_vals/alu_vals
    // after each acceptance. waited = negedges seen before the first grant.
    task automatic both_sources(input int n_rf, input int n_alu, output int waited);
        int ri = 0;
        int ai = 0;
        int t  = 0;
        bit got_rf;
        bit got_alu;
        waited   = -1;
        rf_data  = rf_vals[0];
        rf_vld   = (n_rf > 0);
        alu_data = alu_vals[0];
        alu_vld  = (n_alu > 0);
        while (((ri < n_rf) || (ai < n_alu)) && (t < 500)) begin
            @(negedge clk);
            got_rf  = rf_vld && rf_rdy;
            got_alu = alu_vld && alu_rdy;
            if ((got_rf || got_alu) && (waited < 0)) waited = t;
            t++;
            @(posedge clk);
            #1;
            if (got_rf) begin
                ri++;
                if (ri < n_rf) rf_data = rf_vals[ri];
                else           rf_vld  = 1'b0;
            end
            if (got_alu) begin
                ai++;
                if (ai < n_alu) alu_data = alu_vals[ai];
                else            alu_vld  = 1'b0;
            end
        end
        if ((ri < n_rf) || (ai < n_alu)) begin
            checks++;
            errors++;
            $display("FAIL request_timeout: got %0d rf / %0d alu grants, expected %0d / %0d", ri, ai, n_rf, n_alu);
            rf_vld  = 1'b0;
            alu_vld = 1'b0;
        end
    endtask

    // Counts consecutive BUSY cycles until IDLE, then realigns to posedge+1.
    task automatic wait_idle(input bit use_b, output int n);
        int t = 0;
        bit idle_seen = 1'b0;
        n = 0;
        while (!idle_seen && (t < 300)) begin
            @(negedge clk);
            t++;
            if (use_b ? b_busy : busy) n++;
            else                       idle_seen = 1'b1;
        end
        if (!idle_seen) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy for %0d cycles, expected return to IDLE", n);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n;
        int w;
        int bi;
        int t;
        bit got;

        rst        = 1'b1;
        rf_data    = '0;  rf_vld    = 1'b0;
        alu_data   = '0;  alu_vld   = 1'b0;
        b_rf_data  = '0;  b_rf_vld  = 1'b0;
        b_alu_data = '0;  b_alu_vld = 1'b0;

        // Reset state, with requests present that must not be granted.
        repeat (2) @(posedge clk);
        #1;
        rf_vld = 1'b1; alu_vld = 1'b1; b_rf_vld = 1'b1; b_alu_vld = 1'b1;
        @(negedge clk);
        check("reset_tx_vld", int'(tx_vld), 0);
        check("reset_tx_out", int'(tx_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_busy_b", int'(b_busy), 0);
        check("reset_rf_rdy", int'(rf_rdy), 0);
        @(posedge clk);
        #1;
        rf_vld = 1'b0; alu_vld = 1'b0; b_rf_vld = 1'b0; b_alu_vld = 1'b0;
        rst = 1'b0;

        // Single RF byte.
        rf_vals[0] = 8'hA5;
        exp_q.push_back('{dut: 0, dat: 'hA5, len: H_A});
        acc_a.delete();
        both_sources(1, 0, w);
        check("t1_rf_rdy_same_cycle", w, 0);
        wait_idle(1'b0, n);
        check("t1_busy_cycles", n, H_A + 1);
        check("t1_grant_count", acc_a.size(), 1);
        if (acc_a.size() == 1) check("t1_grant_src", acc_a[0].src, 0);

        // ALU frame, with an RF pulse and ALU_DATA change during HOLD_LO.
        alu_vals[0] = 16'h1234;
        exp_q.push_back('{dut: 0, dat: 'h34, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'h12, len: H_A});
        acc_a.delete();
        both_sources(0, 1, w);
        check("t2_alu_rdy_same_cycle", w, 0);
        fork
            wait_idle(1'b0, n);
            begin
                repeat (3) @(posedge clk);
                #1;
                rf_data = 8'h77; rf_vld = 1'b1; alu_data = 16'hFFFF;
                repeat (4) @(posedge clk);
                #1;
                rf_vld = 1'b0;
            end
        join
        check("t2_busy_cycles", n, 2 * H_A + 2);
        check("t2_grant_count", acc_a.size(), 1);
        if (acc_a.size() == 1) check("t2_grant_src", acc_a[0].src, 1);

        // Both sources held from reset: RF, ALU, RF, ALU.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rf_vals[0]  = 8'h11;     rf_vals[1]  = 8'h33;
        alu_vals[0] = 16'h2B2A;  alu_vals[1] = 16'h4D4C;
        exp_q.push_back('{dut: 0, dat: 'h11, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'h2A, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'h2B, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'h33, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'h4C, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'h4D, len: H_A});
        acc_a.delete();
        both_sources(2, 2, w);
        wait_idle(1'b0, n);
        check("t3_grant_count", acc_a.size(), 4);
        if (acc_a.size() == 4) begin
            check("t3_grant0_src", acc_a[0].src, 0);
            check("t3_grant1_src", acc_a[1].src, 1);
            check("t3_grant2_src", acc_a[2].src, 0);
            check("t3_grant3_src", acc_a[3].src, 1);
            check("t3_rf_spacing", acc_a[1].cyc - acc_a[0].cyc, H_A + 2);
            check("t3_alu_spacing", acc_a[2].cyc - acc_a[1].cyc, 2 * H_A + 3);
            check("t3_rf_spacing2", acc_a[3].cyc - acc_a[2].cyc, H_A + 2);
        end
        check("t3_queue_drained", exp_q.size(), 0);

        // Reset in cycle 5 of HOLD_HI, with RF and ALU pending.
        alu_vals[0] = 16'h5678;
        exp_q.push_back('{dut: 0, dat: 'h78, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'h56, len: 5});
        acc_a.delete();
        both_sources(0, 1, w);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        rf_data = 8'h9C; rf_vld = 1'b1; alu_data = 16'hABAC; alu_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_tx_vld_after_reset", int'(tx_vld), 0);
        check("t4_tx_out_after_reset", int'(tx_out), 0);
        check("t4_busy_after_reset", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rf_vals[0]  = 8'h9C;
        alu_vals[0] = 16'hABAC;
        exp_q.push_back('{dut: 0, dat: 'h9C, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'hAC, len: H_A});
        exp_q.push_back('{dut: 0, dat: 'hAB, len: H_A});
        both_sources(1, 1, w);
        check("t4_rdy_first_cycle_after_reset", w, 0);
        wait_idle(1'b0, n);
        check("t4_grant_count", acc_a.size(), 3);
        if (acc_a.size() == 3) begin
            check("t4_first_after_reset_src", acc_a[1].src, 0);
            check("t4_second_after_reset_src", acc_a[2].src, 1);
        end

        // Single-cycle hold: back-to-back RF, then one ALU frame.
        exp_q.push_back('{dut: 1, dat: 'h01, len: H_B});
        exp_q.push_back('{dut: 1, dat: 'h02, len: H_B});
        exp_q.push_back('{dut: 1, dat: 'h03, len: H_B});
        acc_b.delete();
        bi = 0;
        t  = 0;
        b_rf_data = 8'h01;
        b_rf_vld  = 1'b1;
        while ((bi < 3) && (t < 100)) begin
            @(negedge clk);
            got = b_rf_vld && b_rf_rdy;
            t++;
            @(posedge clk);
            #1;
            if (got) begin
                bi++;
                if (bi < 3) b_rf_data = 8'(bi + 1);
                else        b_rf_vld  = 1'b0;
            end
        end
        b_rf_vld = 1'b0;
        check("t5_rf_accepted", bi, 3);
        wait_idle(1'b1, n);
        check("t5_last_rf_busy", n, H_B + 1);
        check("t5_grant_count", acc_b.size(), 3);
        if (acc_b.size() == 3) begin
            check("t5_spacing01", acc_b[1].cyc - acc_b[0].cyc, H_B + 2);
            check("t5_spacing12", acc_b[2].cyc - acc_b[1].cyc, H_B + 2);
        end
        exp_q.push_back('{dut: 1, dat: 'hEF, len: H_B});
        exp_q.push_back('{dut: 1, dat: 'hCD, len: H_B});
        b_alu_data = 16'hCDEF;
        b_alu_vld  = 1'b1;
        @(negedge clk);
        check("t5_alu_rdy", int'(b_alu_rdy), 1);
        @(posedge clk);
        #1;
        b_alu_vld = 1'b0;
        wait_idle(1'b1, n);
        check("t5_alu_busy", n, 2 * H_B + 2);

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
